// File: rtl/feeder_scheduler.sv
// feeder_scheduler: load strobe + skewed per-row shift enables for systolic feeders.
// Optional stall gating of the feed phase: define FEEDER_SCHED_STALL_EN.
module feeder_scheduler #(
  parameter int N_ROWS = 7,
  parameter int DEPTH  = 7,
  parameter int DRAIN  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  output logic [N_ROWS-1:0] load,
  output logic [N_ROWS-1:0] shift_en,
  output logic              busy,
  output logic              done
);

  localparam int NSLOT = DEPTH + N_ROWS - 1;
  localparam int TW    = $clog2(DEPTH + N_ROWS);
  localparam int DW    = (DRAIN > 0) ? $clog2(DRAIN + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [TW-1:0]     t_q, t_d;
  logic [DW-1:0]     d_q, d_d;
  logic [N_ROWS-1:0] load_q, load_d;
  logic [N_ROWS-1:0] shift_q, shift_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              hold;

`ifdef FEEDER_SCHED_STALL_EN
  assign hold = stall;
`else
  logic unused_stall;
  assign unused_stall = stall;
  assign hold = 1'b0;
`endif

  // t is the next feed slot to emit; row r is live for slots r .. r+DEPTH-1
  function automatic logic [N_ROWS-1:0] pattern(input logic [TW-1:0] t);
    logic [N_ROWS-1:0] v;
    v = '0;
    for (int r = 0; r < N_ROWS; r++) begin
      v[r] = (int'(t) >= r) && (int'(t) < r + DEPTH);
    end
    return v;
  endfunction

  // next state and next registered outputs
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    d_d     = d_q;
    load_d  = '0;
    shift_d = '0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          load_d  = '1;
          busy_d  = 1'b1;
        end
      end
      S_LOAD: begin
        state_d = S_FEED;
        shift_d = pattern('0);
        t_d     = TW'(1);
        busy_d  = 1'b1;
      end
      S_FEED: begin
        busy_d = 1'b1;
        if (int'(t_q) == NSLOT) begin
          t_d = '0;
          d_d = '0;
          if (DRAIN == 0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_DRAIN;
          end
        end else if (!hold) begin
          shift_d = pattern(t_q);
          t_d     = t_q + TW'(1);
        end
      end
      S_DRAIN: begin
        busy_d = 1'b1;
        if (int'(d_q) == DRAIN - 1) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          d_d     = '0;
        end else begin
          d_d = d_q + DW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // state, counters and output registers; reset clears outputs at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      d_q     <= '0;
      load_q  <= '0;
      shift_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      d_q     <= d_d;
      load_q  <= load_d;
      shift_q <= shift_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign load     = load_q;
  assign shift_en = shift_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_feeder_scheduler.sv
// tb_feeder_scheduler: scoreboard bench for feeder_scheduler.
// Expected cycles are derived from the start edge and stall schedule.
module tb_feeder_scheduler;

  localparam int N  = 7;
  localparam int D  = 7;
  localparam int R  = 4;
  localparam int SN = 4;
  localparam int SD = 3;
  localparam int SR = 0;
`ifdef FEEDER_SCHED_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic start_s = 1'b0;
  logic stall = 1'b0;
  logic [N-1:0] load, shift_en;
  logic busy, done;
  logic [SN-1:0] load_s, shift_s;
  logic busy_s, done_s;

  typedef struct packed {
    logic [6:0] load;
    logic [6:0] shift;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t q[$];
  exp_t qs[$];
  int checks = 0;
  int errors = 0;
  int row_cnt[N];

  always #5 clk = ~clk;

  feeder_scheduler #(.N_ROWS(N), .DEPTH(D), .DRAIN(R)) u_dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .load(load), .shift_en(shift_en), .busy(busy), .done(done)
  );

  feeder_scheduler #(.N_ROWS(SN), .DEPTH(SD), .DRAIN(SR)) u_small (
    .clk(clk), .reset(reset), .start(start_s), .stall(1'b0),
    .load(load_s), .shift_en(shift_s), .busy(busy_s), .done(done_s)
  );

  // expected cycles 1..done relative to the start edge k
  task automatic push_burst(input bit sm, input int s0, input int slen);
    int n, dep, dr, sl, last, ce;
    exp_t e;
    n    = sm ? SN : N;
    dep  = sm ? SD : D;
    dr   = sm ? SR : R;
    sl   = STALL_EN ? slen : 0;
    last = 1 + (dep + n - 1 + sl) + dr + 1;
    for (int c = 1; c <= last; c++) begin
      e = '0;
      e.busy = 1'b1;
      if (c == 1) e.load = sm ? 7'h0F : 7'h7F;
      ce = c;
      if (sl > 0 && c >= s0) ce = (c < s0 + sl) ? -100 : c - sl;
      for (int r = 0; r < n; r++) begin
        if (ce >= 2 + r && ce <= 1 + r + dep) e.shift[r] = 1'b1;
      end
      if (c == last) e.done = 1'b1;
      if (sm) qs.push_back(e);
      else q.push_back(e);
    end
  endtask

  task automatic push_idle(input bit sm);
    exp_t e;
    e = '0;
    if (sm) qs.push_back(e);
    else q.push_back(e);
  endtask

  // start high in cycles 0..hi_until-1; stall makes cycles s0.. stalled
  task automatic run(input int hi_until, input bit sm,
                     input int s0, input int slen);
    int j;
    exp_t e;
    foreach (row_cnt[r]) row_cnt[r] = 0;
    @(negedge clk);
    stall = 1'b0;
    if (sm) start_s = 1'b1;
    else start = 1'b1;
    j = 0;
    while ((q.size() > 0 || qs.size() > 0) && j < 200) begin
      @(posedge clk);
      #1;
      j++;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (load !== e.load || shift_en !== e.shift ||
            busy !== e.busy || done !== e.done) begin
          errors++;
          $display("FAIL main cyc %0d load=%h/%h shift=%h/%h busy=%b/%b done=%b/%b",
                   j, load, e.load, shift_en, e.shift, busy, e.busy, done, e.done);
        end
        for (int r = 0; r < N; r++) row_cnt[r] += int'(shift_en[r]);
      end
      if (qs.size() > 0) begin
        e = qs.pop_front();
        checks++;
        if (load_s !== e.load[SN-1:0] || shift_s !== e.shift[SN-1:0] ||
            busy_s !== e.busy || done_s !== e.done) begin
          errors++;
          $display("FAIL small cyc %0d load=%h/%h shift=%h/%h busy=%b/%b done=%b/%b",
                   j, load_s, e.load[SN-1:0], shift_s, e.shift[SN-1:0],
                   busy_s, e.busy, done_s, e.done);
        end
      end
      @(negedge clk);
      start   = !sm && (j < hi_until);
      start_s = sm && (j < hi_until);
      stall   = (j + 1 >= s0) && (j + 1 < s0 + slen);
    end
    if (j >= 200) begin
      errors++;
      $display("FAIL timeout queue=%0d/%0d required=0", q.size(), qs.size());
      q.delete();
      qs.delete();
    end
    start = 1'b0;
    start_s = 1'b0;
    stall = 1'b0;
  endtask

  task automatic check_rows(input string tag);
    for (int r = 0; r < N; r++) begin
      checks++;
      if (row_cnt[r] !== D) begin
        errors++;
        $display("FAIL %s row %0d enables=%0d required=%0d", tag, r, row_cnt[r], D);
      end
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({load, shift_en, busy, done, load_s, shift_s, busy_s, done_s} !== '0) begin
      errors++;
      $display("FAIL reset outs=%h/%h %b %b required=0", load, shift_en, busy, done);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({load, shift_en, busy, done} !== '0) begin
      errors++;
      $display("FAIL idle outs=%h/%h %b %b required=0", load, shift_en, busy, done);
    end
  endtask

  task automatic test_basic();
    push_burst(1'b0, 0, 0);
    push_idle(1'b0);
    run(1, 1'b0, 0, 0);
    check_rows("basic");
  endtask

  task automatic test_stall();
    push_burst(1'b0, 5, 2);
    push_idle(1'b0);
    run(1, 1'b0, 5, 2);
    check_rows("stall");
  endtask

  task automatic test_back_to_back();
    push_burst(1'b0, 0, 0);
    push_idle(1'b0);
    push_burst(1'b0, 0, 0);
    push_idle(1'b0);
    push_idle(1'b0);
    run(21, 1'b0, 0, 0);
  endtask

  task automatic test_abort();
    bit seen_done;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    checks++;
    if (shift_en !== 7'h7C || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre shift=%h busy=%b required=7c 1", shift_en, busy);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({load, shift_en, busy, done} !== '0) begin
      errors++;
      $display("FAIL abort_async outs=%h/%h %b %b required=0", load, shift_en, busy, done);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1;
      if (done || busy || shift_en != '0) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_quiet activity=%b required=0", seen_done);
    end
    push_burst(1'b0, 0, 0);
    push_idle(1'b0);
    run(1, 1'b0, 0, 0);
    check_rows("after_abort");
  endtask

  task automatic test_small();
    push_burst(1'b1, 0, 0);
    push_idle(1'b1);
    run(1, 1'b1, 0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_abort();
    test_small();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
